// File: rtl/stack_engine.sv
// Byte-wide push/pop stack that grows down, backed by a word-wide memory
// with byte enables and a req/ack handshake that tolerates variable latency.
module stack_engine #(
  parameter int WORD  = 8,
  parameter int LANES = 2,
  parameter int SPW   = 16,
  parameter int AW    = 24,
  parameter int DEPTH = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WORD-1:0]       din,
  output logic                  ready,
  output logic [WORD-1:0]       dout,
  output logic                  dout_valid,
  output logic [SPW-1:0]        sp,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [LANES-1:0]      mem_be,
  output logic [AW-1:0]         mem_addr,
  output logic [LANES*WORD-1:0] mem_wdata,
  input  logic [LANES*WORD-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int LB  = $clog2(LANES);
  localparam int LBW = (LB > 0) ? LB : 1;
  localparam logic [SPW-1:0] SP_TOP  = '1;
  localparam logic [SPW-1:0] DEPTH_V = SPW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t         state;
  logic [LBW-1:0] lane;
  logic [SPW-1:0] sp_up;

  // The upper address bits above the slot's word index are tied high.
  function automatic logic [AW-1:0] slot_addr(input logic [SPW-1:0] s);
    logic [AW-1:0] a;
    a = '1;
    a[SPW-LB-1:0] = s[SPW-1:LB];
    return a;
  endfunction

  function automatic logic [LBW-1:0] slot_lane(input logic [SPW-1:0] s);
    return (LB > 0) ? s[LBW-1:0] : '0;
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(input logic [LBW-1:0] k);
    logic [LANES-1:0] b;
    for (int i = 0; i < LANES; i++) b[i] = (k == LBW'(i));
    return b;
  endfunction

  // Lane 0 sits in the most significant slice of the memory word.
  function automatic logic [WORD-1:0] lane_data(input logic [LANES*WORD-1:0] w,
                                                 input logic [LBW-1:0] k);
    logic [WORD-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (k == LBW'(i)) r = w[(LANES-1-i)*WORD +: WORD];
    return r;
  endfunction

  assign sp_up = sp + 1'b1;
  assign ready = (state == IDLE);
  assign empty = (sp == SP_TOP);
  assign full  = ((SP_TOP - sp) == DEPTH_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sp         <= SP_TOP;
      lane       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      dout_valid <= 1'b0;
      // Error sets below come later in this block, so they win over clear.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (push && pop && !empty) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= slot_addr(sp_up);
            mem_be    <= lane_onehot(slot_lane(sp_up));
            mem_wdata <= {LANES{din}};
            state     <= WR;
          end else if (push) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              sp        <= sp - 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= slot_addr(sp);
              mem_be    <= lane_onehot(slot_lane(sp));
              mem_wdata <= {LANES{din}};
              state     <= WR;
            end
          end else if (pop) begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              sp       <= sp_up;
              lane     <= slot_lane(sp_up);
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= slot_addr(sp_up);
              mem_be   <= '1;
              state    <= RD;
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        RD: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            dout       <= lane_data(mem_rdata, lane);
            dout_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// Directed and randomized checks of stack_engine (DEPTH=3) against a queue-based
// stack model and an associative-array memory responder.
module tb_stack_engine;

  localparam int DEPTH = 3;

  logic        clk, rst, push, pop, clear_err, mem_ack;
  logic [7:0]  din, dout;
  logic [15:0] sp, mem_rdata, mem_wdata;
  logic [23:0] mem_addr;
  logic [1:0]  mem_be;
  logic        ready, dout_valid, empty, full, overflow, underflow, mem_req, mem_we;

  stack_engine #(.WORD(8), .LANES(2), .SPW(16), .AW(24), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .ready(ready),
    .dout(dout), .dout_valid(dout_valid), .sp(sp), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .clear_err(clear_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: front of the queue is the top of the stack.
  logic [7:0]  stk[$];
  logic [15:0] mem_model[logic [23:0]];
  logic        m_ovf, m_unf;
  logic [7:0]  m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command from idle through completion; expectations come from the model.
  task automatic cmd(input bit p, input bit q, input logic [7:0] d, input bit clr, input int dly);
    int          kind;
    logic [15:0] msp, slot, mword;
    logic [7:0]  exp_d;
    kind  = 0;
    slot  = '0;
    exp_d = '0;
    msp   = 16'hFFFF - 16'(stk.size());
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && q && stk.size() != 0) begin
      kind = 3; slot = msp + 16'd1; stk[0] = d;
    end else if (p) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else begin kind = 1; slot = msp; stk.push_front(d); end
    end else if (q) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else begin kind = 2; slot = msp + 16'd1; exp_d = stk.pop_front(); end
    end

    push = p; pop = q; din = d; clear_err = clr;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; din = 8'($urandom);

    chk("sp", sp, 16'hFFFF - 16'(stk.size()));
    chk("empty", empty, stk.size() == 0);
    chk("full", full, stk.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);

    if (kind != 0) begin
      chk("ready_busy", ready, 1'b0);
      chk("mem_req", mem_req, 1'b1);
      chk("mem_we", mem_we, kind != 2);
      chk("mem_addr", mem_addr, {9'h1FF, slot[15:1]});
      chk("mem_be", mem_be, (kind == 2) ? 2'b11 : (slot[0] ? 2'b10 : 2'b01));
      if (kind != 2) chk("mem_wdata", mem_wdata, {d, d});
      for (int i = 0; i < dly; i++) begin
        push = 1'($urandom); pop = 1'($urandom); din = 8'($urandom);
        @(negedge clk);
        chk("req_hold", mem_req, 1'b1);
        chk("addr_hold", mem_addr, {9'h1FF, slot[15:1]});
      end
      push = 1'($urandom); pop = 1'($urandom);
      if (mem_we) begin
        mword = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
        if (mem_be[0]) mword[15:8] = mem_wdata[15:8];
        if (mem_be[1]) mword[7:0]  = mem_wdata[7:0];
        mem_model[mem_addr] = mword;
      end else begin
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; push = 1'b0; pop = 1'b0; mem_rdata = 16'($urandom);
      chk("ready_done", ready, 1'b1);
      chk("req_drop", mem_req, 1'b0);
      chk("dout_valid", dout_valid, kind == 2);
      chk("overflow_busy", overflow, m_ovf);
    end else begin
      chk("no_req", mem_req, 1'b0);
      chk("ready_idle", ready, 1'b1);
      chk("no_valid", dout_valid, 1'b0);
    end
    if (kind == 2) m_dout = exp_d;
    chk("dout", dout, m_dout);
    $display("txn push=%0d pop=%0d clr=%0d din=%h dly=%0d sp=%h dout=%h ovf=%0d unf=%0d",
             p, q, clr, d, dly, sp, dout, overflow, underflow);
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; din = '0; clear_err = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("rst_sp", sp, 16'hFFFF);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_unf", underflow, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_be", mem_be, 2'b00);
    chk("rst_addr", mem_addr, 24'h0);
    chk("rst_wdata", mem_wdata, 16'h0);

    // Two pushes, then two pops
    cmd(1, 0, 8'hA1, 0, 0);
    cmd(1, 0, 8'hB2, 0, 0);
    chk("sp_two_pushes", sp, 16'hFFFD);
    cmd(0, 1, 8'h00, 0, 0);
    chk("pop1_dout", dout, 8'hB2);
    cmd(0, 1, 8'h00, 0, 0);
    chk("pop2_dout", dout, 8'hA1);
    chk("empty_after_pops", empty, 1'b1);

    // Underflow, clear, and set-beats-clear
    cmd(0, 1, 8'h00, 0, 0);
    cmd(0, 0, 8'h00, 1, 0);
    cmd(0, 1, 8'h00, 1, 0);
    cmd(0, 0, 8'h00, 1, 0);

    // Depth guard, replace-top while full, drain
    cmd(1, 0, 8'h01, 0, 1);
    cmd(1, 0, 8'h02, 0, 2);
    cmd(1, 0, 8'h03, 0, 0);
    cmd(1, 0, 8'h04, 0, 0);
    cmd(1, 1, 8'h05, 0, 1);
    repeat (3) cmd(0, 1, 8'h00, 0, 1);
    cmd(0, 0, 8'h00, 1, 0);

    // Replace top
    cmd(1, 0, 8'h11, 0, 0);
    cmd(1, 1, 8'h22, 0, 0);
    cmd(0, 1, 8'h00, 0, 0);
    chk("replace_dout", dout, 8'h22);
    cmd(1, 1, 8'h33, 0, 0);
    cmd(0, 1, 8'h00, 0, 0);

    // Reset during a read waiting on a slow ack
    cmd(1, 0, 8'h5A, 0, 0);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("abort_req_up", mem_req, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_req_drop", mem_req, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_sp", sp, 16'hFFFF);
    stk.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    @(negedge clk);
    rst = 1'b1;
    mem_rdata = 16'h5A5A;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_valid", dout_valid, 1'b0);
    chk("late_ack_dout", dout, 8'h00);
    chk("late_ack_req", mem_req, 1'b0);
    chk("late_ack_ready", ready, 1'b1);

    // Randomized command stream
    for (int n = 0; n < 300; n++) begin
      int r;
      bit p, q;
      r = int'($urandom_range(0, 9));
      p = (r < 4) || (r == 8);
      q = ((r >= 4) && (r < 8)) || (r == 8);
      cmd(p, q, 8'($urandom), $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
